// File: rtl/itlb_miss_handler_pkg.sv
// Shared widths, state encoding and PTE address helper for the iTLB miss handler.
package itlb_miss_handler_pkg;

  localparam int VIRT_ADDR_WIDTH    = 32;
  localparam int PHY_ADDR_WIDTH     = 20;
  localparam int PHY_PAGE_NUM_WIDTH = 8;
  localparam int PAGE_SIZE          = 4096;
  localparam int PAGE_OFFSET_WIDTH  = $clog2(PAGE_SIZE);
  localparam int PTE_BYTES_LOG2     = 2;
  // Only these low VPN bits survive the shift-by-2 and truncation to a PTE address.
  localparam int VPN_KEEP_WIDTH     = PHY_ADDR_WIDTH - PTE_BYTES_LOG2;

  // Each non-idle state owns one bit, so the outputs are plain flop outputs.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_WALK  = 3'b001,
    ST_FILL  = 3'b010,
    ST_FAULT = 3'b100
  } state_t;

  localparam int ST_BIT_WALK  = 0;
  localparam int ST_BIT_FILL  = 1;
  localparam int ST_BIT_FAULT = 2;

  function automatic logic [PHY_ADDR_WIDTH-1:0] pte_addr(
    input logic [PHY_ADDR_WIDTH-1:0] base,
    input logic [VPN_KEEP_WIDTH-1:0] vpn
  );
    return base + {vpn, {PTE_BYTES_LOG2{1'b0}}};
  endfunction

endpackage

// File: rtl/itlb_miss_handler.sv
// Single-level page-table walker: on an iTLB miss, reads one PTE and either
// fills the iTLB with its PPN or raises a held page fault.
module itlb_miss_handler
  import itlb_miss_handler_pkg::*;
#(
  parameter int PTE_VALID_BIT = 31,
  parameter int PTE_PPN_LSB   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tlb_miss,
  input  logic [VIRT_ADDR_WIDTH-1:0]    VirtualAddr,
  input  logic [PHY_ADDR_WIDTH-1:0]     ptbr,
  output logic                          mem_req,
  output logic [PHY_ADDR_WIDTH-1:0]     mem_addr,
  input  logic                          mem_ready,
  input  logic [31:0]                   mem_rdata,
  output logic                          tlb_write,
  output logic [PHY_PAGE_NUM_WIDTH-1:0] physical_page_num_mem,
  output logic                          page_fault,
  input  logic                          fault_ack,
  output logic                          busy
);

  state_t                          r_state;
  state_t                          w_state_next;
  logic [VPN_KEEP_WIDTH-1:0]       r_vpn;
  logic [PHY_PAGE_NUM_WIDTH-1:0]   r_ppn;
  logic                            w_pte_valid;
  logic                            w_walk_done;
  logic                            w_unused;

  assign w_pte_valid = mem_rdata[PTE_VALID_BIT];
  assign w_walk_done = r_state[ST_BIT_WALK] & mem_ready;
  assign w_unused    = ^{VirtualAddr[VIRT_ADDR_WIDTH-1:PAGE_OFFSET_WIDTH+VPN_KEEP_WIDTH],
                         VirtualAddr[PAGE_OFFSET_WIDTH-1:0], mem_rdata};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vpn <= '0;
    end else if ((r_state == ST_IDLE) && tlb_miss) begin
      r_vpn <= VirtualAddr[PAGE_OFFSET_WIDTH +: VPN_KEEP_WIDTH];
    end
  end

  // A non-resident PTE leaves the previous PPN on the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ppn <= '0;
    end else if (w_walk_done && w_pte_valid) begin
      r_ppn <= mem_rdata[PTE_PPN_LSB +: PHY_PAGE_NUM_WIDTH];
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (tlb_miss)  w_state_next = ST_WALK;
      ST_WALK:  if (mem_ready) w_state_next = w_pte_valid ? ST_FILL : ST_FAULT;
      ST_FILL:                 w_state_next = ST_IDLE;
      ST_FAULT: if (fault_ack) w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  assign mem_req               = r_state[ST_BIT_WALK];
  assign tlb_write             = r_state[ST_BIT_FILL];
  assign page_fault            = r_state[ST_BIT_FAULT];
  assign busy                  = |r_state;
  assign mem_addr              = mem_req ? pte_addr(ptbr, r_vpn) : '0;
  assign physical_page_num_mem = r_ppn;

endmodule
